// File: rtl/inst_mem_arbiter.sv
// rtl/inst_mem_arbiter.sv - instruction memory shared between fetch and loader
// BOOT gives the loader exclusive access; RUN favours fetch with bounded loader starvation.
module inst_mem_arbiter #(
  parameter int REG_SIZE        = 32,
  parameter int MEM_SIZE_IN_KB  = 1,
  parameter int NO_OF_REGS      = MEM_SIZE_IN_KB*1024/4,
  parameter int MAX_FETCH_BURST = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fetch_req_i,
  input  logic [REG_SIZE-1:0] fetch_addr_i,
  output logic                fetch_gnt_o,
  output logic                fetch_rvalid_o,
  output logic [REG_SIZE-1:0] fetch_rdata_o,
  input  logic                ld_req_i,
  input  logic [REG_SIZE-1:0] ld_addr_i,
  input  logic [REG_SIZE-1:0] ld_wdata_i,
  output logic                ld_gnt_o,
  input  logic                ld_start_i,
  input  logic                ld_done_i,
  output logic                core_hold_o,
  output logic                ld_err_o
);

  localparam int IDX_W = REG_SIZE - 2;
  localparam int AW    = (NO_OF_REGS > 1) ? $clog2(NO_OF_REGS) : 1;
  localparam int CNT_W = $clog2(MAX_FETCH_BURST + 1);
  localparam logic [REG_SIZE-1:0] NOP     = REG_SIZE'(32'h0000_0013);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MAX_FETCH_BURST);

  typedef enum logic {ST_BOOT, ST_RUN} state_e;

  state_e              r_state;
  logic [CNT_W-1:0]    r_starve_cnt;
  logic                r_core_hold;
  logic                r_ld_err;
  logic                r_rvalid;
  logic [REG_SIZE-1:0] r_rdata;
  logic [REG_SIZE-1:0] r_mem [NO_OF_REGS];

  logic [IDX_W-1:0] w_fetch_idx;
  logic [IDX_W-1:0] w_ld_idx;
  logic             w_fetch_in_range;
  logic             w_ld_in_range;
  logic [AW-1:0]    w_fetch_waddr;
  logic [AW-1:0]    w_ld_waddr;
  logic             w_fetch_gnt;
  logic             w_ld_gnt;
  logic             w_unused;

  assign w_fetch_idx      = fetch_addr_i[REG_SIZE-1:2];
  assign w_ld_idx         = ld_addr_i[REG_SIZE-1:2];
  assign w_fetch_in_range = w_fetch_idx < IDX_W'(NO_OF_REGS);
  assign w_ld_in_range    = w_ld_idx < IDX_W'(NO_OF_REGS);
  assign w_fetch_waddr    = w_fetch_idx[AW-1:0];
  assign w_ld_waddr       = w_ld_idx[AW-1:0];
  assign w_unused         = &{1'b0, fetch_addr_i[1:0], ld_addr_i[1:0]};

  // Loader wins a contended cycle only once fetch has used up its burst allowance.
  always_comb begin
    w_fetch_gnt = 1'b0;
    w_ld_gnt    = 1'b0;
    if (rst_ni) begin
      if (r_state == ST_BOOT) begin
        w_ld_gnt = ld_req_i;
      end else begin
        w_fetch_gnt = fetch_req_i && !(ld_req_i && (r_starve_cnt == CNT_MAX));
        w_ld_gnt    = ld_req_i && !w_fetch_gnt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= ST_BOOT;
      r_core_hold  <= 1'b1;
      r_starve_cnt <= '0;
      r_rvalid     <= 1'b0;
      r_rdata      <= NOP;
      r_ld_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (ld_done_i) begin
            r_state     <= ST_RUN;
            r_core_hold <= 1'b0;
          end
        end
        default: begin
          if (ld_start_i) begin
            r_state     <= ST_BOOT;
            r_core_hold <= 1'b1;
          end
        end
      endcase

      if (w_ld_gnt || !ld_req_i) begin
        r_starve_cnt <= '0;
      end else if (w_fetch_gnt && (r_starve_cnt != CNT_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      r_rvalid <= w_fetch_gnt;
      if (w_fetch_gnt) begin
        r_rdata <= w_fetch_in_range ? r_mem[w_fetch_waddr] : NOP;
      end

      if (w_ld_gnt && !w_ld_in_range) begin
        r_ld_err <= 1'b1;
      end
    end
  end

  // Storage has no reset so it maps onto plain RAM and survives a core reset.
  always_ff @(posedge clk_i) begin
    if (w_ld_gnt && w_ld_in_range) begin
      r_mem[w_ld_waddr] <= ld_wdata_i;
    end
  end

  assign fetch_gnt_o    = w_fetch_gnt;
  assign ld_gnt_o       = w_ld_gnt;
  assign fetch_rvalid_o = r_rvalid;
  assign fetch_rdata_o  = r_rdata;
  assign core_hold_o    = r_core_hold;
  assign ld_err_o       = r_ld_err;

endmodule
